// File: rtl/sub48_pkg.sv
// Shared types and helpers for the digit-serial subtractor family.
package sub48_pkg;
   localparam int WIDTH_DEF   = 48;
   localparam int DIGIT_W_DEF = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction
endpackage

// File: rtl/serial_sub48_if.sv
// Operand/result handshake bundle; ovf exists only when SUB_OVF_EN is defined.
interface serial_sub48_if import sub48_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SUB_OVF_EN
   logic             ovf;

   modport slave (input in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf);
   modport master (output in_valid, a, b, out_ready,
                   input in_ready, out_valid, diff, borrow, ovf);
`else
   modport slave (input in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow);
   modport master (output in_valid, a, b, out_ready,
                   input in_ready, out_valid, diff, borrow);
`endif
endinterface

// File: rtl/sub_digit.sv
// Combinational DIGIT_W-bit subtract cell: full-adder chain on a + ~b + ~bin.
module sub_digit #(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] a_dig,
   input  logic [DIGIT_W-1:0] b_dig,
   input  logic               bin,
   output logic [DIGIT_W-1:0] d,
   output logic               bout
);
   logic [DIGIT_W:0]   w_c;
   logic [DIGIT_W-1:0] w_nb;

   assign w_nb   = ~b_dig;
   assign w_c[0] = ~bin;

   for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
      assign d[i]     = a_dig[i] ^ w_nb[i] ^ w_c[i];
      assign w_c[i+1] = (a_dig[i] & w_nb[i]) | (w_c[i] & (a_dig[i] ^ w_nb[i]));
   end

   // a carry out of the chain means no borrow was needed
   assign bout = ~w_c[DIGIT_W];
endmodule

// File: rtl/serial_sub48.sv
// Digit-serial a - b, LSB digit first; SUB_OVF_EN adds a registered signed-overflow flag.
// IDLE | accepting operands;  RUN | one digit per clk;  DONE | result held until out_ready
module serial_sub48 import sub48_pkg::*; #(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DIGIT_W = DIGIT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   serial_sub48_if.slave s_if
);
   localparam int N     = WIDTH / DIGIT_W;
   localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit
      $error("serial_sub48: DIGIT_W must divide WIDTH");
   end

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_diff;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_borrow_q;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [DIGIT_W-1:0] w_d;
   logic               w_bout;
   logic [WIDTH-1:0]   w_d_top;

   sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
      .a_dig (r_a[DIGIT_W-1:0]),
      .b_dig (r_b[DIGIT_W-1:0]),
      .bin   (r_borrow_q),
      .d     (w_d),
      .bout  (w_bout)
   );

   assign w_d_top = WIDTH'(w_d) << (WIDTH - DIGIT_W);

`ifdef SUB_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == IDLE && r_in_ready && s_if.in_valid) begin
         r_a_msb <= s_if.a[WIDTH-1];
         r_b_msb <= s_if.b[WIDTH-1];
         r_ovf   <= 1'b0;
      end else if (r_state == RUN && r_cnt == LAST) begin
         // the last digit's top bit becomes diff[WIDTH-1]
         r_ovf <= (r_a_msb != r_b_msb) && (w_d[DIGIT_W-1] != r_a_msb);
      end
   end

   assign s_if.ovf = r_ovf;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_diff      <= '0;
         r_cnt       <= '0;
         r_borrow_q  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_in_ready && s_if.in_valid) begin
                  r_a        <= s_if.a;
                  r_b        <= s_if.b;
                  r_cnt      <= '0;
                  r_borrow_q <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_a        <= r_a >> DIGIT_W;
               r_b        <= r_b >> DIGIT_W;
               r_diff     <= (r_diff >> DIGIT_W) | w_d_top;
               r_borrow_q <= w_bout;
               r_cnt      <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (s_if.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s_if.in_ready  = r_in_ready;
   assign s_if.out_valid = r_out_valid;
   assign s_if.diff      = r_diff;
   assign s_if.borrow    = r_borrow_q;
endmodule

// File: tb/tb_serial_sub48.sv
// Scoreboard bench for serial_sub48 (WIDTH=48, DIGIT_W=4); checks ovf when SUB_OVF_EN is defined.
module tb_serial_sub48;
   import sub48_pkg::*;

   localparam int W = 48;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [49:0] sb_q[$];

   serial_sub48_if #(.WIDTH(W)) sif ();

   serial_sub48 #(.WIDTH(W), .DIGIT_W(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .s_if (sif)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // {ovf, borrow, diff} from a 49-bit subtraction
   function automatic logic [49:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W:0] r;
      logic       o;
      r = {1'b0, av} - {1'b0, bv};
      o = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
      return {o, r};
   endfunction

   task automatic do_accept(input logic [W-1:0] av, input logic [W-1:0] bv, input int gap);
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      sif.a        = av;
      sif.b        = bv;
      sif.in_valid = 1'b1;
      n = 0;
      while (sif.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (sif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b required 1", sif.in_ready);
         sif.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      sb_q.push_back(model(av, bv));
   endtask

   task automatic do_collect(input int stall, input bit rdy_early, input string nm, output int lat);
      logic [49:0] exp;
      sif.out_ready = rdy_early;
      lat = 0;
      while (sif.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++;
      if (sif.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_out_timeout: out_valid=%b required 1", nm, sif.out_valid);
         sif.out_ready = 1'b0;
         return;
      end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s_unexpected: result with empty scoreboard", nm);
         return;
      end
      exp = sb_q.pop_front();
      if (stall > 0) sif.out_ready = 1'b0;
      checks++;
      if (sif.diff !== exp[W-1:0]) begin
         errors++;
         $display("FAIL %s_diff: got %012h required %012h", nm, sif.diff, exp[W-1:0]);
      end
      checks++;
      if (sif.borrow !== exp[W]) begin
         errors++;
         $display("FAIL %s_borrow: got %b required %b", nm, sif.borrow, exp[W]);
      end
`ifdef SUB_OVF_EN
      checks++;
      if (sif.ovf !== exp[W+1]) begin
         errors++;
         $display("FAIL %s_ovf: got %b required %b", nm, sif.ovf, exp[W+1]);
      end
`endif
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         checks++;
         if (sif.diff !== exp[W-1:0] || sif.borrow !== exp[W] || sif.out_valid !== 1'b1 ||
             sif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: cyc %0d diff=%012h borrow=%b out_valid=%b in_ready=%b required %012h %b 1 0",
                     nm, i, sif.diff, sif.borrow, sif.out_valid, sif.in_ready, exp[W-1:0], exp[W]);
         end
      end
      sif.out_ready = 1'b1;
      @(posedge clk); #1;
      sif.out_ready = 1'b0;
      checks++;
      if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_handshake: out_valid=%b in_ready=%b required 0 1", nm, sif.out_valid, sif.in_ready);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      sif.in_valid  = 1'b0;
      sif.a         = '0;
      sif.b         = '0;
      sif.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0 || sif.diff !== '0 || sif.borrow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%012h borrow=%b required 1 0 0 0",
                  sif.in_ready, sif.out_valid, sif.diff, sif.borrow);
      end
`ifdef SUB_OVF_EN
      checks++;
      if (sif.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: got %b required 0", sif.ovf);
      end
`endif
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat;
      do_accept(48'h000000000005, 48'h000000000003, 0);
      do_collect(0, 1'b1, "basic", lat);
      checks++;
      if (lat != 12) begin
         errors++;
         $display("FAIL basic_latency: got %0d required 12", lat);
      end
      checks++;
      if (sif.diff !== 48'h000000000002) begin
         errors++;
         $display("FAIL basic_diff_const: got %012h required 000000000002", sif.diff);
      end
   endtask

   task automatic test_boundaries();
      int lat;
      do_accept(48'h000000000000, 48'h000000000001, 0);
      do_collect(0, 1'b0, "zero_minus_one", lat);
      do_accept(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1);
      do_collect(0, 1'b0, "a_eq_b", lat);
      checks++;
      if (sif.diff !== '0 || sif.borrow !== 1'b0) begin
         errors++;
         $display("FAIL a_eq_b_const: diff=%012h borrow=%b required 0 0", sif.diff, sif.borrow);
      end
      do_accept(48'h000000000000, 48'hFFFFFFFFFFFF, 2);
      do_collect(0, 1'b0, "zero_minus_ones", lat);
      checks++;
      if (sif.diff !== 48'h000000000001 || sif.borrow !== 1'b1) begin
         errors++;
         $display("FAIL zero_minus_ones_const: diff=%012h borrow=%b required 000000000001 1", sif.diff, sif.borrow);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      do_accept(48'h123456789ABC, 48'h000000000ABC, 0);
      sif.a        = 48'hDEADBEEF0000;
      sif.b        = 48'h000000000001;
      sif.in_valid = 1'b1;
      do_collect(5, 1'b0, "backpressure", lat);
      sif.in_valid = 1'b0;
      checks++;
      if (sif.diff !== 48'h123456789000) begin
         errors++;
         $display("FAIL backpressure_const: got %012h required 123456789000", sif.diff);
      end
      repeat (15) begin @(posedge clk); #1; end
      checks++;
      if (sif.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ignored_in_valid: out_valid=%b required 0", sif.out_valid);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      do_accept(48'h000000ABCDEF, 48'h000000012345, 0);
      repeat (6) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      void'(sb_q.pop_back());
      checks++;
      if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_async: out_valid=%b in_ready=%b required 0 1", sif.out_valid, sif.in_ready);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      repeat (14) begin @(posedge clk); #1; end
      checks++;
      if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_no_output: out_valid=%b in_ready=%b required 0 1", sif.out_valid, sif.in_ready);
      end
      do_accept(48'h000000000010, 48'h000000000001, 0);
      do_collect(0, 1'b0, "after_abort", lat);
      checks++;
      if (sif.diff !== 48'h00000000000F || sif.borrow !== 1'b0) begin
         errors++;
         $display("FAIL after_abort_const: diff=%012h borrow=%b required 00000000000F 0", sif.diff, sif.borrow);
      end
   endtask

`ifdef SUB_OVF_EN
   task automatic test_ovf();
      int lat;
      do_accept(48'h7FFFFFFFFFFF, 48'hFFFFFFFFFFFF, 0);
      do_collect(0, 1'b0, "ovf_set", lat);
      checks++;
      if (sif.ovf !== 1'b1 || sif.diff !== 48'h800000000000 || sif.borrow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_const: ovf=%b diff=%012h borrow=%b required 1 800000000000 1",
                  sif.ovf, sif.diff, sif.borrow);
      end
      do_accept(48'h000000000005, 48'h000000000003, 0);
      do_collect(0, 1'b0, "ovf_clear", lat);
      checks++;
      if (sif.ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear_const: got %b required 0", sif.ovf);
      end
   endtask
`endif

   task automatic test_random();
      int          lat;
      logic [63:0] ta;
      logic [63:0] tb;
      for (int i = 0; i < 300; i++) begin
         ta = {$urandom(), $urandom()};
         tb = {$urandom(), $urandom()};
         if ($urandom_range(0, 9) == 0) tb = ta;
         do_accept(ta[W-1:0], tb[W-1:0], $urandom_range(0, 3));
         do_collect($urandom_range(0, 3), 1'($urandom_range(0, 1)), "random", lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_backpressure();
      test_reset_abort();
`ifdef SUB_OVF_EN
      test_ovf();
`endif
      test_random();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
